// File: rtl/trellis_bank_ctrl.sv
// Address and control sequencer for the Viterbi survivor-path memories: four-bank
// ping-pong trellis addressing, trace-back unit steering and display-memory control.
module trellis_bank_ctrl #(
  parameter int AW = 10
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              enable_i,
  output logic [3:0]        bank_we_o,
  output logic [4*AW-1:0]   bank_addr_o,
  output logic [1:0]        tbu_en_o,
  output logic [1:0]        tbu_sel_o,
  output logic [7:0]        tbu_src_o,
  output logic [2*AW-1:0]   disp_addr_o,
  output logic              disp_out_sel_o,
  output logic              block_done_o
);

  localparam logic [AW-1:0] CNT_MAX  = {AW{1'b1}};
  localparam logic [AW-1:0] RD_INIT  = {{(AW-1){1'b1}}, 1'b0};
  localparam logic [AW-1:0] DRD_INIT = {{(AW-2){1'b1}}, 2'b01};
  localparam logic [AW-1:0] DWR_INIT = AW'(2);

  logic [AW-1:0]   wr_cnt_q, wr_cnt_d, rd_cnt_q, rd_cnt_d;
  logic [AW-1:0]   dwr_cnt_q, dwr_cnt_d, drd_cnt_q, drd_cnt_d;
  logic [1:0]      wr_bank_q, wr_bank_d, b_d1_q, b_d2_q;
  logic            wr_wrap_s;
  logic [3:0]      bank_we_q, bank_we_d;
  logic [4*AW-1:0] bank_addr_q, bank_addr_d;
  logic [1:0]      tbu_en_q, tbu_en_d, tbu_sel_q, tbu_sel_d;
  logic [7:0]      tbu_src_q, tbu_src_d;
  logic [1:0]      tbu0_s0_s, tbu0_s1_s, tbu1_s0_s, tbu1_s1_s;
  logic            ds_q;
  logic [1:0]      ds_dly_q;
  logic            disp_out_sel_q;
  logic [2*AW-1:0] disp_addr_q, disp_addr_d;

  always_comb begin
    wr_wrap_s    = enable_i && (wr_cnt_q == CNT_MAX);
    block_done_o = wr_wrap_s && !rst_i;
    wr_cnt_d     = enable_i ? wr_cnt_q + AW'(1) : {AW{1'b0}};
    rd_cnt_d     = enable_i ? rd_cnt_q - AW'(1) : rd_cnt_q;
    wr_bank_d    = wr_wrap_s ? wr_bank_q + 2'd1 : wr_bank_q;
    dwr_cnt_d    = enable_i ? dwr_cnt_q - AW'(1) : DWR_INIT;
    drd_cnt_d    = enable_i ? drd_cnt_q + AW'(1) : DRD_INIT;
  end

  // Bank role is fixed by its distance from the write bank: 0 write, 2 idle, 1/3 read.
  always_comb begin
    bank_we_d   = 4'b0000;
    bank_addr_d = {(4*AW){1'b0}};
    for (int i = 0; i < 4; i++) begin
      bank_we_d[i] = (wr_bank_q == 2'(i));
      case (2'(i) - wr_bank_q)
        2'd0:    bank_addr_d[i*AW +: AW] = wr_cnt_q;
        2'd2:    bank_addr_d[i*AW +: AW] = {AW{1'b0}};
        default: bank_addr_d[i*AW +: AW] = rd_cnt_q;
      endcase
    end
  end

  always_comb begin
    tbu_en_d  = tbu_en_q | {b_d2_q == 2'd3, b_d2_q == 2'd2};
    tbu_sel_d = {~b_d2_q[0], b_d2_q[0]};
    if (b_d2_q[1]) begin
      tbu0_s0_s = 2'd1;
      tbu0_s1_s = 2'd0;
    end else begin
      tbu0_s0_s = 2'd3;
      tbu0_s1_s = 2'd2;
    end
    if (b_d2_q[1] == b_d2_q[0]) begin
      tbu1_s0_s = 2'd2;
      tbu1_s1_s = 2'd1;
    end else begin
      tbu1_s0_s = 2'd0;
      tbu1_s1_s = 2'd3;
    end
    tbu_src_d   = {tbu1_s1_s, tbu1_s0_s, tbu0_s1_s, tbu0_s0_s};
    disp_addr_d = ds_q ? {drd_cnt_q, dwr_cnt_q} : {dwr_cnt_q, drd_cnt_q};
  end

  // disp_out_sel trails the display-address stage by two cycles (three flops after ds).
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_cnt_q       <= {AW{1'b0}};
      rd_cnt_q       <= RD_INIT;
      dwr_cnt_q      <= DWR_INIT;
      drd_cnt_q      <= DRD_INIT;
      wr_bank_q      <= 2'd0;
      b_d1_q         <= 2'd0;
      b_d2_q         <= 2'd0;
      bank_we_q      <= 4'b0000;
      bank_addr_q    <= {(4*AW){1'b0}};
      tbu_en_q       <= 2'b00;
      tbu_sel_q      <= 2'b00;
      tbu_src_q      <= 8'h00;
      ds_q           <= 1'b0;
      ds_dly_q       <= 2'b00;
      disp_out_sel_q <= 1'b0;
      disp_addr_q    <= {(2*AW){1'b0}};
    end else begin
      wr_cnt_q       <= wr_cnt_d;
      rd_cnt_q       <= rd_cnt_d;
      dwr_cnt_q      <= dwr_cnt_d;
      drd_cnt_q      <= drd_cnt_d;
      wr_bank_q      <= wr_bank_d;
      b_d1_q         <= wr_bank_q;
      b_d2_q         <= b_d1_q;
      bank_we_q      <= bank_we_d;
      bank_addr_q    <= bank_addr_d;
      tbu_en_q       <= tbu_en_d;
      tbu_sel_q      <= tbu_sel_d;
      tbu_src_q      <= tbu_src_d;
      ds_q           <= b_d2_q[0];
      ds_dly_q       <= {ds_dly_q[0], ds_q};
      disp_out_sel_q <= ds_dly_q[1];
      disp_addr_q    <= disp_addr_d;
    end
  end

  assign bank_we_o      = bank_we_q;
  assign bank_addr_o    = bank_addr_q;
  assign tbu_en_o       = tbu_en_q;
  assign tbu_sel_o      = tbu_sel_q;
  assign tbu_src_o      = tbu_src_q;
  assign disp_addr_o    = disp_addr_q;
  assign disp_out_sel_o = disp_out_sel_q;

endmodule
